// File: rtl/n64_poll_engine.sv
// N64 controller poll engine.
// Each trigger in IDLE sends the 0x01 poll command on the open-drain data line.
// It then receives the 32-bit status word and publishes it with a one-cycle valid strobe.
// Ports:
//   clk, rst (sync, active-high)   : clock and reset
//   trigger                         : one-cycle start pulse, ignored while busy
//   data_in                         : raw asynchronous pad level
//   data_oe                         : 1 = pull pad low, 0 = release
//   buttons / valid                 : last good status word (bit 31 first received) + strobe
//   busy / timeout_err              : transaction in flight / RX abandoned strobe
module n64_poll_engine #(
  parameter int CYC_US     = 12,
  parameter int TIMEOUT_US = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger,
  input  logic        data_in,
  output logic        data_oe,
  output logic [31:0] buttons,
  output logic        valid,
  output logic        busy,
  output logic        timeout_err
);

  localparam int BIT_CYC = 4 * CYC_US;
  localparam int TO_CYC  = TIMEOUT_US * CYC_US;
  localparam int CW      = $clog2(TO_CYC + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TX      = 3'd1,
    TX_STOP = 3'd2,
    RX_WAIT = 3'd3,
    RX_BIT  = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [4:0]     bit_cnt;
  logic [31:0]    shreg;
  logic           sync1, sync2, sync_prev;
  logic           fall;
  logic           tx_bit_end;
  logic           rx_sample;

  // Two-flop synchroniser plus one history flop for edge detection.
  // Idle level of the line is high, so all three reset to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync1     <= data_in;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign fall       = sync_prev & ~sync2;
  assign tx_bit_end = (state == TX) && (cnt == CW'(BIT_CYC - 1));
  assign rx_sample  = (state == RX_BIT) && (cnt == CW'(2 * CYC_US - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger) state_nxt = TX;
      TX:      if (tx_bit_end && bit_cnt == 5'd0) state_nxt = TX_STOP;
      TX_STOP: if (cnt == CW'(CYC_US - 1)) state_nxt = RX_WAIT;
      // A falling edge takes priority over the timeout terminal count.
      RX_WAIT: begin
        if (fall)                        state_nxt = RX_BIT;
        else if (cnt == CW'(TO_CYC))     state_nxt = IDLE;
      end
      RX_BIT:  if (rx_sample) state_nxt = (bit_cnt == 5'd0) ? DONE : RX_WAIT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: shared cycle counter, bit counter, shift register, status word.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_cnt <= 5'd0;
      shreg   <= 32'd0;
      buttons <= 32'd0;
    end else begin
      // Counter restarts on every state change and on each TX bit boundary;
      // parked at zero while idle so it can never wrap.
      if (state_nxt != state || tx_bit_end || state == IDLE || state == DONE)
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);

      case (state)
        IDLE: begin
          if (trigger) begin
            bit_cnt <= 5'd7;
            shreg   <= 32'h0000_0001;
          end
        end
        TX: begin
          if (tx_bit_end) begin
            shreg <= shreg << 1;
            if (bit_cnt != 5'd0) bit_cnt <= bit_cnt - 5'd1;
          end
        end
        TX_STOP: begin
          if (state_nxt == RX_WAIT) bit_cnt <= 5'd31;
        end
        RX_BIT: begin
          if (rx_sample) begin
            shreg <= {shreg[30:0], sync2};
            // Publish on the 32nd bit so buttons is already new while valid is high.
            if (bit_cnt == 5'd0) buttons <= {shreg[30:0], sync2};
            else                 bit_cnt <= bit_cnt - 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs. TX sends shreg[7]: '1' = short low pulse, '0' = long low pulse.
  always_comb begin
    data_oe     = 1'b0;
    valid       = 1'b0;
    busy        = (state != IDLE);
    timeout_err = 1'b0;
    case (state)
      TX:      data_oe = shreg[7] ? (cnt < CW'(CYC_US)) : (cnt < CW'(3 * CYC_US));
      TX_STOP: data_oe = 1'b1;
      RX_WAIT: timeout_err = !fall && (cnt == CW'(TO_CYC));
      DONE:    valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_n64_poll_engine.sv
// Directed bench for n64_poll_engine: drives triggers, models the controller reply on the
// open-drain line and compares outputs against hand-derived timing at default parameters.
module tb_n64_poll_engine;

  logic        clk;
  logic        rst;
  logic        trigger;
  logic        data_in;
  logic        data_oe;
  logic [31:0] buttons;
  logic        valid;
  logic        busy;
  logic        timeout_err;

  logic        ctrl_low;
  logic        glitch;

  int n_checks = 0;
  int n_errors = 0;

  // Open-drain line: low if either side pulls; glitch inverts it for a cycle.
  assign data_in = ~(data_oe | ctrl_low) ^ glitch;

  n64_poll_engine dut (
    .clk         (clk),
    .rst         (rst),
    .trigger     (trigger),
    .data_in     (data_in),
    .data_oe     (data_oe),
    .buttons     (buttons),
    .valid       (valid),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full transaction window of 4096 cycles from trigger to next trigger.
  // k = 0 is the first cycle after the accepted trigger. Release of the line is at k=396,
  // the controller starts replying 2 us later at k=420.
  task automatic run_txn(input string tag, input bit reply, input logic [31:0] word,
                         input bit glitch_en, input int retrig_k, input logic [31:0] exp_btn);
    int          oe_err, busy_err, nvalid, nto, to_k, i, w;
    logic        exp_oe;
    logic [31:0] vbtn;
    oe_err = 0; busy_err = 0; nvalid = 0; nto = 0; to_k = -1; vbtn = 32'd0;
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    for (int k = 0; k < 4095; k++) begin
      // observe
      exp_oe = 1'b0;
      if (k < 384) begin
        w = k % 48;
        exp_oe = ((k / 48) == 7) ? (w < 12) : (w < 36);
      end else if (k < 396) begin
        exp_oe = 1'b1;
      end
      if (data_oe !== exp_oe) oe_err++;
      if (k < 396 && busy !== 1'b1) busy_err++;
      if (valid === 1'b1) begin
        nvalid++;
        vbtn = buttons;
      end
      if (timeout_err === 1'b1) begin
        nto++;
        to_k = k;
      end
      // drive
      ctrl_low = 1'b0;
      glitch   = 1'b0;
      trigger  = (k == retrig_k);
      if (reply && k >= 420) begin
        i = (k - 420) / 48;
        w = (k - 420) % 48;
        if (i < 32) begin
          ctrl_low = word[31-i] ? (w < 12) : (w < 36);
          glitch   = glitch_en && (w == 16);
        end else if (i == 32) begin
          ctrl_low = (w < 12);
        end
      end
      @(negedge clk);
    end
    ctrl_low = 1'b0;
    glitch   = 1'b0;
    trigger  = 1'b0;
    check({tag, "_oe_wave"},  32'(oe_err),   32'd0);
    check({tag, "_busy_tx"},  32'(busy_err), 32'd0);
    check({tag, "_nvalid"},   32'(nvalid),   reply ? 32'd1 : 32'd0);
    check({tag, "_ntimeout"}, 32'(nto),      reply ? 32'd0 : 32'd1);
    if (reply) check({tag, "_btn_at_valid"}, vbtn, word);
    else       check({tag, "_timeout_cyc"}, 32'(to_k), 32'd2796);
    check({tag, "_btn_after"}, buttons, exp_btn);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; trigger = 1'b0; ctrl_low = 1'b0; glitch = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_oe",      32'(data_oe),     32'd0);
    check("rst_busy",    32'(busy),        32'd0);
    check("rst_valid",   32'(valid),       32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_buttons", buttons,          32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // basic poll
    run_txn("t1", 1'b1, 32'h8000_0001, 1'b0, -1, 32'h8000_0001);
    // no reply -> timeout, buttons kept
    run_txn("t2", 1'b0, 32'h0, 1'b0, -1, 32'h8000_0001);
    // retrigger during TX ignored
    run_txn("t3", 1'b1, 32'h1234_ABCD, 1'b0, 100, 32'h1234_ABCD);

    // reset in the middle of TX
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    repeat (150) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t4_oe",      32'(data_oe), 32'd0);
    check("t4_busy",    32'(busy),    32'd0);
    check("t4_buttons", buttons,      32'd0);
    // reset and trigger together: reset wins
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    check("t4_rst_trig_busy", 32'(busy),    32'd0);
    check("t4_rst_trig_oe",   32'(data_oe), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    run_txn("t4b", 1'b1, 32'h5A5A_0FF0, 1'b0, -1, 32'h5A5A_0FF0);

    // back-to-back extremes
    run_txn("t5a", 1'b1, 32'hFFFF_FFFF, 1'b0, -1, 32'hFFFF_FFFF);
    run_txn("t5b", 1'b1, 32'h0000_0000, 1'b0, -1, 32'h0000_0000);

    // single-cycle glitches inside each received bit
    run_txn("t6", 1'b1, 32'hA5C3_3C5A, 1'b1, -1, 32'hA5C3_3C5A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
